delay_tap_controller: RTL and testbench
=======================================

Name: delay_tap_controller

Overview:
Control block for the fixed-depth delay-line bank (taps of 30, 45, 60 and 90 samples). It gates sample shifting into the bank and drives the tap-select mux. It tracks how many samples have been shifted since the last clear, so output is flagged valid only once the selected line holds real data. Tap changes arrive on a valid/ready handshake and are applied through a guard window. Sits between the top-level pin logic and the delay-line bank plus output mux.

Parameters:
NUM_TAPS, 4, number of delay lines in the bank
TAP_W, 2, width of tap index
CNT_W, 7, width of fill counter (must hold MAX_DEPTH)
GUARD, 2, cycles out_valid stays low after a tap switch (1..7)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
sample_valid  in  1  new input sample present this cycle
sel_req_valid  in  1  tap-change request valid
sel_req_tap  in  TAP_W  requested tap index
sel_req_ready  out  1  controller can accept tap request
flush_req  in  1  request to clear all delay lines
line_en  out  1  shift enable to delay-line bank
line_clear  out  1  one-cycle synchronous clear to delay-line bank
tap_sel  out  TAP_W  output mux select
primed  out  1  level: selected line fully filled (state RUN)
out_valid  out  1  pulse: mux output carries a valid delayed sample
fill_cnt  out  CNT_W  samples shifted since last clear, saturating
err_bad_tap  out  1  one-cycle pulse: request for tap >= NUM_TAPS

Behaviour:
- Reset values: state FILL, tap_sel 0, fill_cnt 0; line_clear, primed, out_valid and err_bad_tap all 0. Reset acts immediately and mid-operation.
- States: FILL, RUN, SWITCH, FLUSH.
- line_en = sample_valid && state != FLUSH (combinational). sample_valid during FLUSH is dropped.
- fill_cnt increments on each line_en and saturates at MAX_DEPTH (90). It is common to all taps because the bank shifts in lockstep.
- FILL: when line_en raises fill_cnt to DEPTH[tap_sel] or above, move to RUN in the next cycle.
- RUN: primed=1. out_valid is registered, equal to line_en delayed one cycle, and gated by RUN. It is never high outside RUN.
- sel_req_ready = 1 in FILL and RUN, 0 in SWITCH and FLUSH.
- On accept (valid && ready):
  - tap >= NUM_TAPS: pulse err_bad_tap next cycle. State and tap_sel are unchanged.
  - Otherwise tap_sel takes the new value next cycle and the state goes to SWITCH with guard counter = GUARD.
  - Same tap as current: still goes through SWITCH.
- SWITCH: primed=0, out_valid=0, fill_cnt keeps counting. When the guard expires, go to RUN if fill_cnt >= DEPTH[tap_sel], else FILL.
- flush_req has highest priority in any state:
  - next cycle: line_clear=1, fill_cnt=0, state FLUSH (1 cycle), then FILL.
  - flush_req held high keeps the controller in FLUSH.
- Simultaneous flush_req and accepted valid request: tap_sel updates, flush proceeds, SWITCH is skipped.
- Flush during SWITCH: the guard is abandoned.
- Boundary: fill_cnt stays 90 forever while running. Switching from the 90 tap to the 30 tap with fill_cnt=90 gives RUN right after the guard. Switching from 30 to 90 with fill_cnt=40 gives FILL until 90.

Optional Feature:
TAP_SWEEP_EN — adds input sweep_en (1) and parameter SWEEP_PERIOD (default 256, samples).
- Defined: while sweep_en=1 and state RUN, an internal counter counts line_en. On reaching SWEEP_PERIOD, the controller issues an internal tap switch to (tap_sel+1) mod NUM_TAPS via the normal SWITCH path, and the counter resets.
  - External requests and flush take priority; an external accept resets the counter.
  - sel_req_ready is unchanged.
- Undefined: no port, no counter; tap_sel changes only on external requests.

Decomposition:
- Shared package delay_line_pkg:
  - NUM_TAPS, MAX_DEPTH=90
  - depth constant array DEPTH = {30,45,60,90}
  - state enum (FILL, RUN, SWITCH, FLUSH)
  - tap index typedef
- One natural sub-module: delay_fill_counter (saturating up-counter with clear, enable, and compare-to-depth output).

Test Plan:
1. Reset, tap 0, sample_valid every cycle. Expected: primed rises the cycle after fill_cnt reaches 30; out_valid pulses from then on; fill_cnt holds at 90.
2. fill_cnt=40 in RUN on tap 0, request tap 3. Expected: ready drops; out_valid=0 for 2 cycles; state FILL; RUN after fill_cnt reaches 90.
3. Request tap 3 at fill_cnt=90, then tap 0. Expected: each switch costs exactly GUARD=2 cycles of out_valid=0, then RUN.
4. flush_req one cycle in RUN. Expected: line_clear for one cycle, fill_cnt=0, sample_valid during FLUSH yields line_en=0, state FILL.
5. Request tap 5 with NUM_TAPS=4 (TAP_W=3). Expected: err_bad_tap for one cycle; tap_sel and out_valid unaffected.
6. flush_req together with a request for tap 2. Expected: tap_sel=2, FLUSH then FILL, no SWITCH. Then assert reset mid-FILL: all outputs return to reset values immediately.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared constants and types for the fixed-depth delay-line bank (30/45/60/90 taps)
// and its controller.
package delay_line_pkg;
  localparam int unsigned NUM_TAPS  = 4;
  localparam int unsigned MAX_DEPTH = 90;
  localparam int unsigned DEPTH [NUM_TAPS] = '{30, 45, 60, 90};

  typedef enum logic [1:0] {FILL, RUN, SWITCH, FLUSH} state_t;
  typedef logic [1:0] tap_idx_t;

  // Out-of-range indices map to the deepest line so "full" is never claimed early.
  function automatic int unsigned depth_of(input int unsigned idx);
    if (idx >= NUM_TAPS) return MAX_DEPTH;
    return DEPTH[idx[1:0]];
  endfunction
endpackage

// File: rtl/delay_tap_controller_if.sv
// Tap-change request handshake between pin logic and the delay-tap controller.
interface delay_tap_controller_if #(parameter int TAP_W = 2);
  logic             sel_req_valid;
  logic [TAP_W-1:0] sel_req_tap;
  logic             sel_req_ready;
  logic             err_bad_tap;

  modport master (output sel_req_valid, sel_req_tap, input sel_req_ready, err_bad_tap);
  modport slave  (input sel_req_valid, sel_req_tap, output sel_req_ready, err_bad_tap);
endinterface

// File: rtl/delay_tap_controller_fill_counter.sv
// Saturating count of samples shifted into the bank since the last clear,
// with a compare against the depth of the currently selected line.
module delay_fill_counter #(
  parameter int          CNT_W = 7,
  parameter int unsigned MAX   = 90
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] depth,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (clear)             cnt <= '0;
    else if (en && cnt != CAP)  cnt <= cnt + CNT_W'(1);
  end

  assign full = (cnt >= depth);
endmodule

// File: rtl/delay_tap_controller.sv
// Delay-line bank controller: shift gating, fill tracking, guarded tap switching, flush.
// Optional TAP_SWEEP_EN adds sweep_en / SWEEP_PERIOD for automatic round-robin tap sweeping.
module delay_tap_controller #(
  parameter int NUM_TAPS = delay_line_pkg::NUM_TAPS,
  parameter int TAP_W    = 2,
  parameter int CNT_W    = 7,
  parameter int GUARD    = 2
`ifdef TAP_SWEEP_EN
  , parameter int SWEEP_PERIOD = 256
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_valid,
`ifdef TAP_SWEEP_EN
  input  logic             sweep_en,
`endif
  input  logic             flush_req,
  delay_tap_controller_if.slave req,
  output logic             line_en,
  output logic             line_clear,
  output logic [TAP_W-1:0] tap_sel,
  output logic             primed,
  output logic             out_valid,
  output logic [CNT_W-1:0] fill_cnt
);
  import delay_line_pkg::*;

  state_t           state, nxt;
  logic [2:0]       guard_cnt;
  logic             accept, bad_tap, take_ext, take_sweep, sweep_fire, full;
  logic [TAP_W-1:0] tap_nxt, tap_inc;
  logic [CNT_W-1:0] depth;

  assign line_en           = sample_valid && (state != FLUSH);
  assign req.sel_req_ready = (state == FILL) || (state == RUN);
  assign accept            = req.sel_req_valid && req.sel_req_ready;
  assign bad_tap           = {1'b0, req.sel_req_tap} >= NUM_TAPS[TAP_W:0];
  assign take_ext          = accept && !bad_tap;
  assign take_sweep        = sweep_fire && !accept && !flush_req;
  assign tap_inc           = (tap_sel == TAP_W'(NUM_TAPS - 1)) ? '0 : tap_sel + TAP_W'(1);
  assign tap_nxt           = take_ext ? req.sel_req_tap : tap_inc;
  assign depth             = CNT_W'(depth_of(32'(tap_sel)));

  delay_fill_counter #(.CNT_W(CNT_W), .MAX(MAX_DEPTH)) u_fill (
    .clock (clock),
    .reset (reset),
    .clear (flush_req),
    .en    (line_en),
    .depth (depth),
    .cnt   (fill_cnt),
    .full  (full)
  );

`ifdef TAP_SWEEP_EN
  localparam int SW_W = $clog2(SWEEP_PERIOD + 1);
  logic [SW_W-1:0] sweep_cnt;
  logic            sweep_step;

  assign sweep_step = sweep_en && (state == RUN) && line_en;
  assign sweep_fire = sweep_step && (sweep_cnt == SW_W'(SWEEP_PERIOD - 1));

  // External accepts and flushes restart the sweep period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   sweep_cnt <= '0;
    else if (flush_req || accept || sweep_fire)  sweep_cnt <= '0;
    else if (sweep_step)                         sweep_cnt <= sweep_cnt + SW_W'(1);
  end
`else
  assign sweep_fire = 1'b0;
`endif

  // Flush outranks everything; a request accepted alongside it only moves tap_sel.
  always_comb begin
    nxt = state;
    if (flush_req) nxt = FLUSH;
    else begin
      case (state)
        FLUSH:    nxt = FILL;
        FILL:     if (take_ext || take_sweep) nxt = SWITCH;
                  else if (full)              nxt = RUN;
        RUN:      if (take_ext || take_sweep) nxt = SWITCH;
        SWITCH:   if (guard_cnt <= 3'd1)      nxt = full ? RUN : FILL;
        default:  nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= FILL;
      tap_sel         <= '0;
      guard_cnt       <= '0;
      line_clear      <= 1'b0;
      primed          <= 1'b0;
      out_valid       <= 1'b0;
      req.err_bad_tap <= 1'b0;
    end else begin
      state           <= nxt;
      line_clear      <= flush_req;
      primed          <= (nxt == RUN);
      out_valid       <= line_en && (nxt == RUN);
      req.err_bad_tap <= accept && bad_tap;
      if (take_ext || take_sweep) tap_sel <= tap_nxt;
      if (nxt == SWITCH && state != SWITCH) guard_cnt <= 3'(GUARD);
      else if (state == SWITCH)             guard_cnt <= guard_cnt - 3'd1;
    end
  end
endmodule

// File: tb/tb_delay_tap_controller.sv
// Randomized and directed bench for delay_tap_controller against a cycle-level
// behavioural model built from fill counts, a guard countdown and a flush flag.
module tb_delay_tap_controller;
  localparam int GUARD = 2;

  logic       clock = 1'b0, reset = 1'b0, sample_valid = 1'b0, flush_req = 1'b0;
  logic       line_en, line_clear, primed, out_valid;
  logic [2:0] tap_sel;
  logic [6:0] fill_cnt;

  delay_tap_controller_if #(.TAP_W(3)) rif();

  delay_tap_controller #(.NUM_TAPS(4), .TAP_W(3), .CNT_W(7), .GUARD(GUARD)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
`ifdef TAP_SWEEP_EN
    .sweep_en     (1'b0),
`endif
    .flush_req    (flush_req),
    .req          (rif),
    .line_en      (line_en),
    .line_clear   (line_clear),
    .tap_sel      (tap_sel),
    .primed       (primed),
    .out_valid    (out_valid),
    .fill_cnt     (fill_cnt)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int dep [4] = '{30, 45, 60, 90};
  int m_cnt, m_tap, m_guard;
  bit m_flushing, m_primed, m_ov, m_lc, m_err, m_le;
  logic        obs_le;
  logic [15:0] obs_v, exp_v;

  task automatic model_reset();
    m_cnt = 0; m_tap = 0; m_guard = 0;
    m_flushing = 0; m_primed = 0; m_ov = 0; m_lc = 0; m_err = 0; m_le = 0;
  endtask

  // One clock of stimulus; advances the reference model and captures both vectors.
  task automatic tick(input bit sv, input bit fl, input bit rv, input int tp);
    bit acc, is_bad;
    int old_cnt;
    sample_valid = sv; flush_req = fl; rif.sel_req_valid = rv; rif.sel_req_tap = 3'(tp);
    #1;
    m_le   = sv && !m_flushing;
    obs_le = line_en;
    acc    = rv && !m_flushing && (m_guard == 0);
    is_bad = (tp >= 4);
    @(posedge clock);
    old_cnt = m_cnt;
    if (acc && !is_bad) m_tap = tp;
    if (fl) begin
      m_flushing = 1; m_guard = 0; m_primed = 0;
    end else if (m_flushing) begin
      m_flushing = 0; m_primed = 0;
    end else if (acc && !is_bad) begin
      m_guard = GUARD; m_primed = 0;
    end else if (m_guard > 0) begin
      m_guard--;
      if (m_guard == 0) m_primed = (old_cnt >= dep[m_tap]);
    end else if (!m_primed) begin
      m_primed = (old_cnt >= dep[m_tap]);
    end
    if (fl) m_cnt = 0;
    else if (m_le && m_cnt < 90) m_cnt++;
    m_ov  = m_le && m_primed;
    m_lc  = fl;
    m_err = acc && is_bad;
    #1;
    exp_v = {3'(m_tap), 7'(m_cnt), m_primed, m_ov, m_lc, m_err,
             !m_flushing && (m_guard == 0), m_le};
    obs_v = {tap_sel, fill_cnt, primed, out_valid, line_clear, rif.err_bad_tap,
             rif.sel_req_ready, obs_le};
  endtask

  task automatic do_reset();
    sample_valid = 0; flush_req = 0; rif.sel_req_valid = 0; rif.sel_req_tap = '0;
    reset = 1;
    @(posedge clock); @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    sample_valid = 0; flush_req = 0; rif.sel_req_valid = 0; rif.sel_req_tap = '0;
    #3 reset = 1;
    #1;
    total++;
    if ({tap_sel, fill_cnt, primed, out_valid, line_clear, rif.err_bad_tap} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got tap=%0d cnt=%0d pr=%b ov=%b lc=%b err=%b want all 0",
               tap_sel, fill_cnt, primed, out_valid, line_clear, rif.err_bad_tap);
    end
    @(posedge clock); @(negedge clock);
    reset = 0;
    model_reset();
    total++;
    if (rif.sel_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", rif.sel_req_ready);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      tick(1, 0, 0, 0);
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL fill_vec[%0d]: got %h want %h", i, obs_v, exp_v); end
      if (i == 30) begin
        total++;
        if ({fill_cnt, primed} !== {7'd30, 1'b0}) begin
          bad++; $display("FAIL fill_at30: got cnt=%0d primed=%b want 30/0", fill_cnt, primed);
        end
      end
      if (i == 31) begin
        total++;
        if ({primed, out_valid} !== 2'b11) begin
          bad++; $display("FAIL fill_primed_rise: got pr=%b ov=%b want 1/1", primed, out_valid);
        end
      end
    end
    total++;
    if (fill_cnt !== 7'd90) begin bad++; $display("FAIL fill_saturate: got %0d want 90", fill_cnt); end
  endtask

  task automatic test_switch_fill();
    bit got;
    do_reset();
    repeat (40) tick(1, 0, 0, 0);
    tick(1, 0, 1, 3);
    total++;
    if (obs_v !== exp_v || rif.sel_req_ready !== 1'b0) begin
      bad++; $display("FAIL swfill_accept: got %h want %h (ready must be 0)", obs_v, exp_v);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, 0);
      total++;
      if (obs_v !== exp_v || out_valid !== 1'b0) begin
        bad++; $display("FAIL swfill_guard[%0d]: got %h want %h", i, obs_v, exp_v);
      end
    end
    total++;
    if ({primed, rif.sel_req_ready} !== 2'b01) begin
      bad++; $display("FAIL swfill_state: got pr=%b rdy=%b want FILL 0/1", primed, rif.sel_req_ready);
    end
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      tick(1, 0, 0, 0);
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL swfill_vec[%0d]: got %h want %h", i, obs_v, exp_v); end
      if (primed === 1'b1) begin
        got = 1;
        total++;
        if (fill_cnt !== 7'd90) begin bad++; $display("FAIL swfill_run_cnt: got %0d want 90", fill_cnt); end
      end
    end
    total++;
    if (!got) begin bad++; $display("FAIL swfill_timeout: got no RUN want RUN by cnt 90"); end
  endtask

  task automatic test_switch_run();
    int z;
    int taps [2] = '{3, 0};
    for (int t = 0; t < 2; t++) begin
      tick(1, 0, 1, taps[t]);
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL swrun_accept[%0d]: got %h want %h", t, obs_v, exp_v); end
      z = (out_valid === 1'b0) ? 1 : 0;
      for (int k = 0; k < 10; k++) begin
        tick(1, 0, 0, 0);
        total++;
        if (obs_v !== exp_v) begin bad++; $display("FAIL swrun_vec[%0d]: got %h want %h", t, obs_v, exp_v); end
        if (out_valid === 1'b1) break;
        z++;
      end
      total++;
      if (z != GUARD || tap_sel !== 3'(taps[t])) begin
        bad++; $display("FAIL swrun_gap[%0d]: got gap=%0d tap=%0d want gap=%0d tap=%0d",
                        t, z, tap_sel, GUARD, taps[t]);
      end
    end
  endtask

  task automatic test_flush();
    tick(1, 1, 0, 0);
    total++;
    if ({line_clear, fill_cnt, rif.sel_req_ready} !== {1'b1, 7'd0, 1'b0} || obs_v !== exp_v) begin
      bad++; $display("FAIL flush_enter: got %h want %h", obs_v, exp_v);
    end
    tick(1, 0, 0, 0);
    total++;
    if ({obs_le, line_clear, fill_cnt, primed, rif.sel_req_ready} !== {2'b00, 7'd0, 2'b01}) begin
      bad++; $display("FAIL flush_drop: got le=%b lc=%b cnt=%0d pr=%b rdy=%b want 0/0/0/0/1",
                      obs_le, line_clear, fill_cnt, primed, rif.sel_req_ready);
    end
    tick(1, 0, 0, 0);
    total++;
    if (obs_v !== exp_v || fill_cnt !== 7'd1) begin
      bad++; $display("FAIL flush_refill: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_bad_tap();
    repeat (40) tick(1, 0, 0, 0);
    tick(1, 0, 1, 5);
    total++;
    if ({rif.err_bad_tap, tap_sel, out_valid} !== {1'b1, 3'd0, 1'b1} || obs_v !== exp_v) begin
      bad++; $display("FAIL badtap_pulse: got %h want %h", obs_v, exp_v);
    end
    tick(1, 0, 0, 0);
    total++;
    if ({rif.err_bad_tap, out_valid, rif.sel_req_ready} !== 3'b011 || obs_v !== exp_v) begin
      bad++; $display("FAIL badtap_after: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_flush_with_req();
    tick(1, 1, 1, 2);
    total++;
    if ({tap_sel, line_clear, rif.sel_req_ready} !== {3'd2, 2'b10} || obs_v !== exp_v) begin
      bad++; $display("FAIL flreq_enter: got %h want %h", obs_v, exp_v);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1, 0, 0, 0);
      total++;
      if (obs_v !== exp_v || rif.sel_req_ready !== 1'b1) begin
        bad++; $display("FAIL flreq_fill[%0d]: got %h want %h", i, obs_v, exp_v);
      end
    end
    #2 reset = 1;
    #1;
    total++;
    if ({tap_sel, fill_cnt, primed, out_valid, line_clear, rif.err_bad_tap} !== 14'd0) begin
      bad++; $display("FAIL midreset: got tap=%0d cnt=%0d pr=%b ov=%b want all 0",
                      tap_sel, fill_cnt, primed, out_valid);
    end
    sample_valid = 0; flush_req = 0; rif.sel_req_valid = 0;
    @(posedge clock); @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  task automatic test_random();
    bit sv, fl, rv;
    for (int i = 0; i < 800; i++) begin
      sv = ($urandom_range(0, 4) != 0);
      fl = ($urandom_range(0, 39) == 0);
      rv = ($urandom_range(0, 7) == 0);
      tick(sv, fl, rv, int'($urandom_range(0, 5)));
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL random[%0d]: got %h want %h", i, obs_v, exp_v); end
    end
  endtask

  initial begin
    model_reset();
    rif.sel_req_valid = 0; rif.sel_req_tap = '0;
    test_reset();
    test_fill();
    test_switch_fill();
    test_switch_run();
    test_flush();
    test_bad_tap();
    test_flush_with_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
